// File: rtl/cust_stream_pkg.sv
// Shared widths, beat type and read-FSM states for the channel-tagged sample stream.
package cust_stream_pkg;
  localparam int SAMPLE_W     = 16;
  localparam int CHAN_W       = 8;
  localparam int DEF_NUM_CHAN = 160;

  typedef struct packed {
    logic [SAMPLE_W-1:0] sample;
    logic [CHAN_W-1:0]   num;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM
  } rd_state_e;
endpackage

// File: rtl/pingpong_sample_ram.sv
// Two-bank sample store: one write port, one registered read port; address MSB picks the bank.
module pingpong_sample_ram
  import cust_stream_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int CA_W     = $clog2(NUM_CHAN)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [CA_W:0]       wr_addr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [CA_W:0]       rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);
  logic [SAMPLE_W-1:0] mem_q [2**(CA_W+1)];
  logic [SAMPLE_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/chan_stream_source.sv
// Captures a frame of interleaved words into a ping-pong RAM and streams one sample per
// channel as {sample, num, valid} beats, throttled by the consumer's read strobe.
module chan_stream_source
  import cust_stream_pkg::*;
#(
  parameter int NUM_CHAN       = DEF_NUM_CHAN,
  parameter int WORDS_PER_CHAN = 2,
  parameter int SAMPLE_WORD    = 1,
  parameter int ADDR_W         = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_word,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic                in_we,
  input  logic                in_frame_done,
  output logic [SAMPLE_W-1:0] chan_out_sample,
  output logic [CHAN_W-1:0]   chan_out_num,
  output logic                chan_out_valid,
  input  logic                chan_out_read,
  output logic                busy,
  output logic [15:0]         frame_drop_count
);
  localparam int CA_W = $clog2(NUM_CHAN);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);

  rd_state_e   state_q;
  logic        wr_bank_q;
  logic        pending_q;
  logic        taint_q;
  logic        valid_q;
  beat_t       out_q;
  logic [15:0] drop_q;

  logic [ADDR_W-1:0]   wr_chan;
  logic [ADDR_W-1:0]   wr_word;
  logic                wr_en;
  logic [CHAN_W:0]     rd_chan;
  logic                rd_en;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                done_accept;
  logic                last_beat;

  assign wr_chan = in_addr / ADDR_W'(WORDS_PER_CHAN);
  assign wr_word = in_addr % ADDR_W'(WORDS_PER_CHAN);
  assign wr_en   = in_we && (wr_word == ADDR_W'(SAMPLE_WORD))
                 && (wr_chan < ADDR_W'(NUM_CHAN)) && !pending_q;

  // The RAM always runs one channel ahead of the output register so beats can be back to back.
  always_comb begin
    rd_chan = '0;
    rd_en   = 1'b0;
    if (state_q == ST_PRIME) begin
      rd_en = 1'b1;
    end else if (state_q == ST_STREAM) begin
      rd_chan = valid_q ? ({1'b0, out_q.num} + (CHAN_W+1)'(2)) : (CHAN_W+1)'(1);
      rd_en   = (!valid_q || chan_out_read) && (rd_chan < (CHAN_W+1)'(NUM_CHAN));
    end
  end

  pingpong_sample_ram #(
    .NUM_CHAN (NUM_CHAN),
    .CA_W     (CA_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wr_bank_q, wr_chan[CA_W-1:0]}),
    .wr_data_i (in_word),
    .rd_en_i   (rd_en),
    .rd_addr_i ({~wr_bank_q, rd_chan[CA_W-1:0]}),
    .rd_data_o (ram_rdata)
  );

  assign done_accept = in_frame_done && !pending_q && !taint_q;
  assign last_beat   = valid_q && chan_out_read && (out_q.num == LAST_CHAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      pending_q <= 1'b0;
      taint_q   <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      if (in_frame_done && (pending_q || taint_q) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
      if (in_frame_done)
        taint_q <= 1'b0;
      else if (in_we && pending_q)
        taint_q <= 1'b1;
      // A frame finishing on the final beat is swapped in directly instead of parked.
      if (done_accept && (state_q != ST_IDLE) && !last_beat)
        pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (done_accept) begin
            wr_bank_q <= ~wr_bank_q;
            state_q   <= ST_PRIME;
          end
        end
        ST_PRIME: state_q <= ST_STREAM;
        ST_STREAM: begin
          if (!valid_q) begin
            valid_q      <= 1'b1;
            out_q.sample <= ram_rdata;
            out_q.num    <= '0;
          end else if (last_beat) begin
            valid_q <= 1'b0;
            if (pending_q || done_accept) begin
              wr_bank_q <= ~wr_bank_q;
              pending_q <= 1'b0;
              state_q   <= ST_PRIME;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (chan_out_read) begin
            out_q.sample <= ram_rdata;
            out_q.num    <= out_q.num + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign chan_out_sample  = out_q.sample;
  assign chan_out_num     = out_q.num;
  assign chan_out_valid   = valid_q;
  assign busy             = (state_q != ST_IDLE) || pending_q;
  assign frame_drop_count = drop_q;
endmodule

// File: tb/tb_chan_stream_source.sv
// Scenario bench for chan_stream_source: expected beats are queued at frame_done and
// popped by a negedge monitor whenever a beat is about to transfer.
module tb_chan_stream_source;
  localparam int NCH = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_word = '0;
  logic [8:0]  in_addr = '0;
  logic        in_we = 1'b0;
  logic        in_frame_done = 1'b0;
  logic [15:0] chan_out_sample;
  logic [7:0]  chan_out_num;
  logic        chan_out_valid;
  logic        chan_out_read = 1'b0;
  logic        busy;
  logic [15:0] frame_drop_count;

  int compared = 0;
  int mismatched = 0;
  logic [23:0] exp_q[$];
  bit chk_on = 1'b0;
  int read_mode = 0;  // 0 hold low, 1 hold high, 2 toggle

  chan_stream_source dut (
    .clk              (clk),
    .reset            (reset),
    .in_word          (in_word),
    .in_addr          (in_addr),
    .in_we            (in_we),
    .in_frame_done    (in_frame_done),
    .chan_out_sample  (chan_out_sample),
    .chan_out_num     (chan_out_num),
    .chan_out_valid   (chan_out_valid),
    .chan_out_read    (chan_out_read),
    .busy             (busy),
    .frame_drop_count (frame_drop_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (read_mode == 1) chan_out_read = 1'b1;
    else if (read_mode == 2) chan_out_read = ~chan_out_read;
    else chan_out_read = 1'b0;
  end

  // Beat monitor: compares every transferring beat against the scoreboard and checks stalls.
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [15:0] prev_s = '0;
  logic [7:0]  prev_n = '0;
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      if (prev_v && !prev_r) begin
        compared++;
        if (chan_out_valid !== 1'b1 || chan_out_sample !== prev_s || chan_out_num !== prev_n) begin
          mismatched++;
          $display("FAIL stall_hold: valid=%b num=%0d sample=%0d, required valid=1 num=%0d sample=%0d",
                   chan_out_valid, chan_out_num, chan_out_sample, prev_n, prev_s);
        end
      end
      if (chan_out_valid === 1'b1 && chan_out_read === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat: num=%0d sample=%0d, required no beat", chan_out_num, chan_out_sample);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({chan_out_num, chan_out_sample} !== e) begin
            mismatched++;
            $display("FAIL beat: num=%0d sample=%0d, required num=%0d sample=%0d",
                     chan_out_num, chan_out_sample, e[23:16], e[15:0]);
          end else begin
            $display("beat num=%0d sample=%0d", chan_out_num, chan_out_sample);
          end
        end
      end
      prev_v = chan_out_valid; prev_r = chan_out_read;
      prev_s = chan_out_sample; prev_n = chan_out_num;
    end else begin
      prev_v = 1'b0; prev_r = 1'b0;
    end
  end

  task automatic write_words(input int lo, input int hi, input int mult, input int add, input bit junk);
    for (int a = lo; a < hi; a++) begin
      in_we = 1'b1;
      in_addr = 9'(a);
      in_word = (a % 2 == 1) ? 16'((a / 2) * mult + add) : 16'hDEAD;
      @(posedge clk); #1;
    end
    if (junk) begin
      for (int a = 320; a < 512; a++) begin
        in_we = 1'b1;
        in_addr = 9'(a);
        in_word = 16'hBEEF;
        @(posedge clk); #1;
      end
    end
    in_we = 1'b0;
  endtask

  task automatic pulse_done(input bit accept, input int mult, input int add);
    if (accept)
      for (int c = 0; c < NCH; c++) exp_q.push_back({8'(c), 16'(c * mult + add)});
    in_frame_done = 1'b1;
    @(posedge clk); #1;
    in_frame_done = 1'b0;
    $display("frame_done accept=%0b mult=%0d add=%0d", accept, mult, add);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && i < budget) begin
      @(negedge clk); i++;
    end
    compared++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d beats outstanding busy=%b, required 0 outstanding busy=0",
               name, exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0 || chan_out_num !== 8'd0 || chan_out_sample !== 16'd0 ||
        busy !== 1'b0 || frame_drop_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_state: valid=%b num=%0d sample=%0d busy=%b drops=%0d, required all 0",
               chan_out_valid, chan_out_num, chan_out_sample, busy, frame_drop_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    chk_on = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n = 0;
    read_mode = 1;
    write_words(0, 320, 100, 0, 1'b0);
    pulse_done(1'b1, 100, 0);
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0) begin
      mismatched++; $display("FAIL latency_n1: valid=%b, required 0", chan_out_valid);
    end
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0) begin
      mismatched++; $display("FAIL latency_n2: valid=%b, required 0", chan_out_valid);
    end
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b1 || chan_out_num !== 8'd0) begin
      mismatched++;
      $display("FAIL latency_first: valid=%b num=%0d, required valid=1 num=0", chan_out_valid, chan_out_num);
    end
    for (int i = 0; i < 400; i++) begin
      if (chan_out_valid !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    compared++;
    if (n != NCH) begin
      mismatched++; $display("FAIL consecutive_beats: got %0d, required %0d", n, NCH);
    end
    wait_drain(50, "basic");
    $display("test_basic done");
  endtask

  task automatic test_stall_toggle();
    int n = 0;
    int i = 0;
    read_mode = 2;
    write_words(0, 320, 100, 0, 1'b0);
    pulse_done(1'b1, 100, 0);
    @(negedge clk);
    while (chan_out_valid !== 1'b1 && i < 10) begin
      @(negedge clk); i++;
    end
    for (int k = 0; k < 700; k++) begin
      if (chan_out_valid !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    compared++;
    if (n < 2 * NCH - 1 || n > 2 * NCH) begin
      mismatched++; $display("FAIL toggle_duration: got %0d cycles, required %0d..%0d", n, 2 * NCH - 1, 2 * NCH);
    end
    wait_drain(50, "toggle");
    $display("test_stall_toggle done");
  endtask

  task automatic test_pending_swap();
    int i = 0;
    read_mode = 0;
    write_words(0, 320, 100, 0, 1'b0);
    pulse_done(1'b1, 100, 0);
    write_words(0, 320, 1, 1, 1'b0);
    pulse_done(1'b1, 1, 1);
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || frame_drop_count !== 16'd0) begin
      mismatched++;
      $display("FAIL pending_busy: busy=%b drops=%0d, required busy=1 drops=0", busy, frame_drop_count);
    end
    @(posedge clk); #1;
    // Third frame arrives while one is already parked: dropped.
    write_words(0, 320, 7, 3, 1'b0);
    pulse_done(1'b0, 7, 3);
    @(negedge clk);
    compared++;
    if (frame_drop_count !== 16'd1) begin
      mismatched++; $display("FAIL drop_pending: drops=%0d, required 1", frame_drop_count);
    end
    @(posedge clk); #1;
    write_words(0, 100, 7, 3, 1'b0);
    read_mode = 1;
    @(negedge clk);
    while (!(chan_out_valid === 1'b1 && chan_out_read === 1'b1 && chan_out_num === 8'd159) && i < 600) begin
      @(negedge clk); i++;
    end
    compared++;
    if (i >= 600) begin
      mismatched++; $display("FAIL last_beat_timeout: waited %0d cycles, required < 600", i);
    end
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0) begin
      mismatched++; $display("FAIL swap_gap1: valid=%b, required 0", chan_out_valid);
    end
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0) begin
      mismatched++; $display("FAIL swap_gap2: valid=%b, required 0", chan_out_valid);
    end
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b1 || chan_out_num !== 8'd0 || chan_out_sample !== 16'd1) begin
      mismatched++;
      $display("FAIL swap_first: valid=%b num=%0d sample=%0d, required valid=1 num=0 sample=1",
               chan_out_valid, chan_out_num, chan_out_sample);
    end
    @(posedge clk); #1;
    $display("test_pending_swap done");
  endtask

  task automatic test_taint_drop();
    write_words(100, 320, 7, 3, 1'b0);
    pulse_done(1'b0, 7, 3);
    @(negedge clk);
    compared++;
    if (frame_drop_count !== 16'd2) begin
      mismatched++; $display("FAIL drop_taint: drops=%0d, required 2", frame_drop_count);
    end
    @(posedge clk); #1;
    write_words(0, 320, 5, 9, 1'b1);
    pulse_done(1'b1, 5, 9);
    wait_drain(600, "after_drop");
    compared++;
    if (frame_drop_count !== 16'd2) begin
      mismatched++; $display("FAIL drop_stable: drops=%0d, required 2", frame_drop_count);
    end
    $display("test_taint_drop done");
  endtask

  task automatic test_reset_midstream();
    int i = 0;
    bit seen = 1'b0;
    read_mode = 1;
    write_words(0, 320, 3, 7, 1'b0);
    pulse_done(1'b1, 3, 7);
    @(negedge clk);
    while (!(chan_out_valid === 1'b1 && chan_out_num === 8'd50) && i < 300) begin
      @(negedge clk); i++;
    end
    compared++;
    if (i >= 300) begin
      mismatched++; $display("FAIL ch50_timeout: waited %0d cycles, required < 300", i);
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    compared++;
    if (chan_out_valid !== 1'b0 || chan_out_num !== 8'd0 || frame_drop_count !== 16'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: valid=%b num=%0d drops=%0d busy=%b, required valid=0 num=0 drops=0 busy=0",
               chan_out_valid, chan_out_num, frame_drop_count, busy);
    end
    repeat (20) begin
      @(negedge clk);
      if (chan_out_valid !== 1'b0) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++; $display("FAIL post_reset_quiet: valid seen=1, required 0");
    end
    @(posedge clk); #1;
    write_words(0, 320, 3, 7, 1'b0);
    pulse_done(1'b1, 3, 7);
    wait_drain(300, "post_reset");
    $display("test_reset_midstream done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall_toggle();
    test_pending_swap();
    test_taint_drop();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
